// File: rtl/mem16x2_ctrl_if.sv
// Request/response bundle for the 16x2 memory controller: requests in, registered data and strobes out.
// The master drives requests; the slave (controller) drives data_out and the status strobes.
interface mem16x2_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 2
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              wr_en;
    logic              rd_en;
    logic              clr;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              wr_ack;
    logic              busy;
    logic              err;

    modport master (
        output addr, data_in, wr_en, rd_en, clr,
        input  data_out, rd_valid, wr_ack, busy, err
    );

    modport slave (
        input  addr, data_in, wr_en, rd_en, clr,
        output data_out, rd_valid, wr_ack, busy, err
    );
endinterface

// File: rtl/mem16x2_ctrl.sv
// Small synchronous memory with 1-cycle write ack / registered read and a hardware clear sweep.
// No backpressure: requests arriving during the sweep are dropped and latch the sticky err bit.
module mem16x2_ctrl #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    mem16x2_ctrl_if.slave      bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              wr_ack;
    logic              busy;
    logic              err;

    logic wr_req;
    logic rd_req;
    logic clr_req;

    assign wr_req  = (bus.wr_en == 1'b1);
    assign rd_req  = (bus.rd_en == 1'b1);
    assign clr_req = (bus.clr   == 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
            wr_ack   <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            wr_ack   <= 1'b0;
            case (state)
                IDLE: begin
                    // clr wins the edge: concurrent read/write are dropped without flagging err
                    if (clr_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        if (rd_req) begin
                            data_out <= mem[bus.addr];
                            rd_valid <= 1'b1;
                        end
                        if (wr_req) begin
                            wr_ack <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == {ADDR_W{1'b1}}) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    if (wr_req || rd_req || clr_req) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; writes are simply gated off while rst is held low
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                mem[ptr] <= INIT_VAL;
            end else if (wr_req && !clr_req) begin
                mem[bus.addr] <= bus.data_in;
            end
        end
    end

    assign bus.data_out = data_out;
    assign bus.rd_valid = rd_valid;
    assign bus.wr_ack   = wr_ack;
    assign bus.busy     = busy;
    assign bus.err      = err;
endmodule

// File: doc/mem16x2_ctrl.md
# mem16x2_ctrl

Synchronous 16-word × 2-bit memory with a small controller. It is the downstream consumer of the memory-test stimulus generator's addr_o / data / wr_en bus. It provides:
- single-cycle writes with acknowledge;
- registered reads with a valid strobe;
- a hardware clear sweep that rewrites every location.

Illegal requests are flagged on a sticky error bit so benches can check protocol compliance.

## Interface
- ADDR_W, 4, address width; depth = 2**ADDR_W.
- DATA_W, 2, data width.
- INIT_VAL, 0, value written to every word by the clear sweep (DATA_W bits).

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  word address for read/write.
- data_in  in  DATA_W  write data. May be Z/X when wr_en=0; ignored then.
- wr_en  in  1  write request, sampled at posedge.
- rd_en  in  1  read request, sampled at posedge.
- clr  in  1  start clear sweep, sampled at posedge.
- data_out  out  DATA_W  registered read data; holds last read value.
- rd_valid  out  1  one-cycle strobe: data_out updated by a read.
- wr_ack  out  1  one-cycle strobe: write committed.
- busy  out  1  clear sweep in progress.
- err  out  1  sticky: request sampled while busy.

## Operation
- **FSM states:** IDLE, CLEAR.
- **Reset** (rst=0, asynchronous):
  - state=IDLE, sweep pointer=0.
  - data_out=0, rd_valid=0, wr_ack=0, busy=0, err=0.
  - Memory array is not reset; contents are undefined until written or cleared.

**IDLE**, per posedge:
- wr_en=1: mem[addr] <= data_in; wr_ack=1 for the next cycle.
- rd_en=1: data_out <= mem[addr]; rd_valid=1 for the next cycle.
- wr_en=1 and rd_en=1 on the same edge:
  - Both execute.
  - Read is read-before-write: a same-address read returns the old contents.
- clr=1: go to CLEAR; pointer=0.
  - clr has priority over wr_en/rd_en on the same edge; those requests are dropped and err is not set.
- X/Z on wr_en, rd_en or clr is a bench error. The RTL treats a non-1 value as 0.

**CLEAR**:
- Each posedge writes mem[pointer] <= INIT_VAL, then pointer += 1.
- After writing word 2**ADDR_W−1 (pointer wraps to 0), return to IDLE.
- wr_en, rd_en or clr sampled in CLEAR is ignored: no write, no read strobe, no ack. err is set to 1 and holds until reset.
- data_out is unchanged during CLEAR.

**Reset mid-sweep:**
- State returns to IDLE.
- Already-cleared words keep INIT_VAL; the rest keep their prior contents.

## Timing
- All outputs are registered; no combinational input→output paths.
- **Write latency:** request sampled at posedge N; memory updated at N; wr_ack high from N to N+1.
- **Read latency:** 1 cycle. data_out and rd_valid are valid from posedge N to N+1.
  - rd_valid and wr_ack drop after one cycle unless re-requested.
  - Back-to-back requests on consecutive edges keep the strobes high continuously.
- **Clear:** clr sampled at posedge N.
  - busy=1 from N.
  - Words 0..15 are written at posedges N+1..N+16.
  - busy falls at N+16.
  - Any request sampled at an edge where busy=1 (edges N+1..N+16) is ignored and sets err.
  - The first accepted request is at N+17.
- **Stimulus source timing:** it drives inputs after negedge and holds them past posedge. Inputs must be stable around posedge only.

## Test plan
- **Reset:** assert rst=0 mid-cycle → all outputs 0 immediately, before the next clock edge.
- **Write then read:**
  - Write 2'b10 to addr 4'h3; wr_ack pulses 1 cycle.
  - Read 4'h3 → data_out=2'b10 with a 1-cycle rd_valid.
  - Read 4'h4 after clear → INIT_VAL.
- **Simultaneous read and write:** addr 4'h5 holds 2'b01; wr_en+rd_en with data_in=2'b11 → data_out=2'b01. A following read → 2'b11.
- **Full sweep:**
  - Write 2'b11 to all 16 words, then pulse clr.
  - busy is high for exactly 16 cycles.
  - Read all 16 words → INIT_VAL each; err=0.
- **Busy violation:** wr_en at addr 4'h7 with data 2'b10 during CLEAR → no wr_ack, err=1 sticky. Word 7 reads INIT_VAL after the sweep.
- **Reset mid-sweep:**
  - rst=0 after 5 sweep writes; busy=0 immediately.
  - Words 0–4 read INIT_VAL.
  - Word 10, previously written 2'b11, reads 2'b11.
